// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed driver for a row of 7-segment digits. A packed hex word,
// per-digit decimal points and per-digit enables are captured into a pending
// buffer on `load`. At each frame boundary the pending buffer moves to a
// shadow buffer, so a single frame never mixes old and new values. Each digit
// slot lasts SCAN_DIV clocks. It is split into 16 PWM sub-steps; the digit is
// lit only while the sub-step is below `brightness`. Leading-zero suppression
// is optional.
//
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   data        4*DIGITS hex nibbles, digit 0 in data[3:0]
//   dp          per-digit decimal point request
//   digit_en    per-digit enable (0 forces the digit dark)
//   load        captures data/dp/digit_en into the pending buffer
//   lz_blank    enables leading-zero blanking (live, not buffered)
//   brightness  PWM duty 0..15 (live, not buffered)
//   seg         segments a..g on seg[6]..seg[0]
//   dp_out      decimal point segment
//   an          one-hot digit select
//   frame_tick  one-cycle pulse on the first output cycle of digit 0
// All outputs are registered and lag the scan counters by one clock.
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  load,
    input  logic                  lz_blank,
    input  logic [3:0]            brightness,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int STEP = SCAN_DIV / 16;
    localparam int CW   = $clog2(SCAN_DIV);
    localparam int SW   = (STEP > 1) ? $clog2(STEP) : 1;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]     CYC_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [SW-1:0]     STEP_LAST = SW'(STEP - 1);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0]        SEG_OFF   = {7{SEG_ACTIVE_LOW}};

    // Hex glyph decode, abcdefg, 1 = segment on
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b1011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1111011;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b0011111;
            4'hC:    g = 7'b1001110;
            4'hD:    g = 7'b0111101;
            4'hE:    g = 7'b1001111;
            4'hF:    g = 7'b1000111;
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    logic [CW-1:0]         cyc_r;
    logic [SW-1:0]         step_r;     // position inside the current PWM sub-step
    logic [3:0]            sub_r;      // equals cyc_r / STEP, kept as a counter
    logic [IW-1:0]         idx_r;
    logic [4*DIGITS-1:0]   pend_data_r;
    logic [DIGITS-1:0]     pend_dp_r;
    logic [DIGITS-1:0]     pend_en_r;
    logic [4*DIGITS-1:0]   shadow_data_r;
    logic [DIGITS-1:0]     shadow_dp_r;
    logic [DIGITS-1:0]     shadow_en_r;

    logic                  cyc_wrap_s;
    logic                  frame_wrap_s;
    logic [3:0]            nib_s;
    logic                  en_s;
    logic                  dp_s;
    logic                  blank_s;
    logic                  zero_above_s;
    logic [DIGITS-1:0]     lz_mask_s;
    logic                  lit_s;
    logic [DIGITS-1:0]     an_hot_s;
    logic [6:0]            seg_raw_s;
    logic                  dp_raw_s;

    // Slot and frame boundary detection
    always_comb begin
        cyc_wrap_s   = (cyc_r == CYC_LAST);
        frame_wrap_s = cyc_wrap_s && (idx_r == IDX_LAST);
    end

    // Scan counters: cycle within slot, PWM sub-step, digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_r  <= '0;
            step_r <= '0;
            sub_r  <= 4'd0;
            idx_r  <= '0;
        end else if (cyc_wrap_s) begin
            cyc_r  <= '0;
            step_r <= '0;
            sub_r  <= 4'd0;
            idx_r  <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
        end else begin
            cyc_r <= cyc_r + CW'(1);
            if (step_r == STEP_LAST) begin
                step_r <= '0;
                sub_r  <= sub_r + 4'd1;
            end else begin
                step_r <= step_r + SW'(1);
            end
        end
    end

    // Pending/shadow buffers; a load on the wrap edge bypasses pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data_r   <= '0;
            pend_dp_r     <= '0;
            pend_en_r     <= '0;
            shadow_data_r <= '0;
            shadow_dp_r   <= '0;
            shadow_en_r   <= '0;
        end else begin
            if (load) begin
                pend_data_r <= data;
                pend_dp_r   <= dp;
                pend_en_r   <= digit_en;
            end
            if (frame_wrap_s) begin
                shadow_data_r <= load ? data     : pend_data_r;
                shadow_dp_r   <= load ? dp       : pend_dp_r;
                shadow_en_r   <= load ? digit_en : pend_en_r;
            end
        end
    end

    // Leading-zero mask: digit k>0 is blankable when it and every higher
    // digit is zero, with disabled digits counted as zero
    always_comb begin
        zero_above_s = 1'b1;
        lz_mask_s    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above_s = zero_above_s &&
                           (!shadow_en_r[k] || (shadow_data_r[4*k +: 4] == 4'h0));
            lz_mask_s[k] = zero_above_s && (k != 0);
        end
    end

    // Select the current digit's fields and decide whether it is lit
    always_comb begin
        nib_s    = 4'h0;
        en_s     = 1'b0;
        dp_s     = 1'b0;
        blank_s  = 1'b0;
        an_hot_s = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_r == IW'(k)) begin
                nib_s   = shadow_data_r[4*k +: 4];
                en_s    = shadow_en_r[k];
                dp_s    = shadow_dp_r[k];
                blank_s = lz_blank && lz_mask_s[k];
            end else begin
                nib_s   = nib_s;
            end
        end
        lit_s = en_s && (sub_r < brightness) && !blank_s;
        for (int k = 0; k < DIGITS; k++) begin
            an_hot_s[k] = lit_s && (idx_r == IW'(k));
        end
        seg_raw_s = lit_s ? hex_glyph(nib_s) : 7'b0000000;
        dp_raw_s  = lit_s && dp_s;
    end

    // Registered pin outputs; an and seg always change on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp_out     <= SEG_ACTIVE_LOW;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_hot_s ^ AN_OFF;
            seg        <= seg_raw_s ^ SEG_OFF;
            dp_out     <= dp_raw_s ^ SEG_ACTIVE_LOW;
            frame_tick <= (idx_r == '0) && (cyc_r == '0);
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Self-checking bench for seg_scan_driver with DIGITS=4 and SCAN_DIV=32. A
// reference model tracks the position inside the frame as one integer and
// the pending/shadow buffers as plain variables. It derives every output from
// the scan arithmetic (digit = pos/32, cycle = pos%32, sub-step = cycle/2).
// Directed scenarios add checks against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 32;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  digit_en = 4'h0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [3:0]  brightness = 4'd15;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_tick;

    seg_scan_driver #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .dp(dp), .digit_en(digit_en),
        .load(load), .lz_blank(lz_blank), .brightness(brightness),
        .seg(seg), .dp_out(dp_out), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    int          pos = 0;
    logic [15:0] pend_data = 16'h0, sh_data = 16'h0;
    logic [3:0]  pend_dp = 4'h0, sh_dp = 4'h0;
    logic [3:0]  pend_en = 4'h0, sh_en = 4'h0;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_ft;
    logic [3:0]  obs_an;
    logic [6:0]  obs_seg;
    logic        obs_dp, obs_ft;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic void model_expect();
        int d, c, s;
        logic [15:0] eff;
        logic blank, lit;
        d = pos / SCAN_DIV;
        c = pos % SCAN_DIV;
        s = c / (SCAN_DIV / 16);
        for (int k = 0; k < DIGITS; k++) eff[4*k +: 4] = sh_en[k] ? sh_data[4*k +: 4] : 4'h0;
        blank   = lz_blank && (d > 0) && ((eff >> (4*d)) == 16'h0);
        lit     = sh_en[d] && (s < int'(brightness)) && !blank;
        exp_an  = lit ? ~(4'b0001 << d) : 4'b1111;
        exp_seg = lit ? glyph[sh_data[4*d +: 4]] : 7'h00;
        exp_dp  = lit ? sh_dp[d] : 1'b0;
        exp_ft  = (pos == 0);
    endfunction

    // one clock: predict, advance model, sample DUT and compare
    task automatic step();
        model_expect();
        @(posedge clk);
        if (pos == FRAME - 1) begin
            if (load) {sh_data, sh_dp, sh_en} = {data, dp, digit_en};
            else      {sh_data, sh_dp, sh_en} = {pend_data, pend_dp, pend_en};
        end
        if (load) {pend_data, pend_dp, pend_en} = {data, dp, digit_en};
        pos = (pos + 1) % FRAME;
        #1;
        obs_an = an; obs_seg = seg; obs_dp = dp_out; obs_ft = frame_tick;
        check_val("an",         obs_an,  exp_an);
        check_val("seg",        obs_seg, exp_seg);
        check_val("dp_out",     obs_dp,  exp_dp);
        check_val("frame_tick", obs_ft,  exp_ft);
    endtask

    // reset asserted away from the clock edge, held two edges, released mid-cycle
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check_val("rst_an", an, 4'hF);
        check_val("rst_seg", seg, 7'h00);
        check_val("rst_dp", dp_out, 1'b0);
        check_val("rst_ft", frame_tick, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_hold_an", an, 4'hF);
        check_val("rst_hold_seg", seg, 7'h00);
        pos = 0;
        {pend_data, pend_dp, pend_en} = '0;
        {sh_data, sh_dp, sh_en} = '0;
        #2 rst = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
        data = d; dp = p; digit_en = e; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // run until the next step will emit the first cycle of digit 0
    task automatic to_frame_start();
        int guard = 0;
        while (pos != 0 && guard < FRAME + 2) begin
            step();
            guard++;
        end
        check_val("frame_align", pos, 0);
    endtask

    initial begin
        int cnt, cnt2, bad;
        logic [3:0] an_tab [4];
        logic [6:0] seg_tab [4];
        logic [3:0] dp_tab;
        int lit_cnt [4];

        #1;
        do_reset();
        repeat (50) step();

        // reset mid-scan, then first frame
        brightness = 4'd15;
        do_reset();
        step();
        check_val("first_tick", obs_ft, 1'b1);
        do_load(16'h0000, 4'h0, 4'hF);
        to_frame_start();
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < SCAN_DIV; i++) begin
            step();
            if (obs_an == 4'b1110 && obs_seg == 7'b1111110) cnt++;
            if (obs_an != 4'b1111) cnt2++;
        end
        check_val("d0_zero_cycles", cnt, 30);
        check_val("d0_lit_cycles", cnt2, 30);

        // glyph sweep with decimal point
        do_load(16'h7F3A, 4'b0100, 4'hF);
        to_frame_start();
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{7'b1110111, 7'b1111001, 7'b1000111, 7'b1110000};
        dp_tab  = 4'b0100;
        for (int k = 0; k < DIGITS; k++) begin
            step();
            check_val("sweep_an", obs_an, an_tab[k]);
            check_val("sweep_seg", obs_seg, seg_tab[k]);
            check_val("sweep_dp", obs_dp, dp_tab[k]);
            repeat (SCAN_DIV - 1) step();
        end

        // tear-free update mid-frame
        do_load(16'hFFFF, 4'h0, 4'hF);
        to_frame_start();
        repeat (40) step();
        do_load(16'h1234, 4'h0, 4'hF);
        bad = 0;
        while (pos != 0) begin
            step();
            if (obs_an != 4'b1111 && obs_seg != 7'b1000111) bad++;
        end
        check_val("tear_old_frame", bad, 0);
        seg_tab = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
        for (int k = 0; k < DIGITS; k++) begin
            step();
            check_val("tear_new_seg", obs_seg, seg_tab[k]);
            repeat (SCAN_DIV - 1) step();
        end

        // leading zeros
        lz_blank = 1'b1;
        do_load(16'h0050, 4'h0, 4'hF);
        to_frame_start();
        for (int k = 0; k < DIGITS; k++) begin
            lit_cnt[k] = 0;
            for (int i = 0; i < SCAN_DIV; i++) begin
                step();
                if (i == 0 && k == 0) check_val("lz_d0_seg", obs_seg, 7'b1111110);
                if (i == 0 && k == 1) check_val("lz_d1_seg", obs_seg, 7'b1011011);
                if (obs_an != 4'b1111) lit_cnt[k]++;
            end
        end
        check_val("lz_d0", lit_cnt[0], 30);
        check_val("lz_d1", lit_cnt[1], 30);
        check_val("lz_d2", lit_cnt[2], 0);
        check_val("lz_d3", lit_cnt[3], 0);
        do_load(16'h0000, 4'h0, 4'hF);
        to_frame_start();
        for (int k = 0; k < DIGITS; k++) begin
            lit_cnt[k] = 0;
            for (int i = 0; i < SCAN_DIV; i++) begin
                step();
                if (obs_an != 4'b1111) lit_cnt[k]++;
            end
        end
        check_val("lz0_d0", lit_cnt[0], 30);
        check_val("lz0_rest", lit_cnt[1] + lit_cnt[2] + lit_cnt[3], 0);
        lz_blank = 1'b0;

        // brightness 4 then 0
        brightness = 4'd4;
        do_load(16'h8888, 4'h0, 4'hF);
        to_frame_start();
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < SCAN_DIV; i++) begin
            step();
            if (obs_an != 4'b1111) begin
                cnt++;
                if (i < 8) cnt2++;
            end
        end
        check_val("br4_lit", cnt, 8);
        check_val("br4_early", cnt2, 8);
        brightness = 4'd0;
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            if (obs_an != 4'b1111) cnt++;
            if (obs_ft) cnt2++;
        end
        check_val("br0_an", cnt, 0);
        check_val("br0_ticks", cnt2, 3);
        brightness = 4'd15;

        // load on the wrap edge
        begin
            int guard = 0;
            while (pos != FRAME - 1 && guard < FRAME + 2) begin
                step();
                guard++;
            end
        end
        do_load(16'hC0DE, 4'b0001, 4'hF);
        step();
        check_val("wrap_load_an", obs_an, 4'b1110);
        check_val("wrap_load_seg", obs_seg, 7'b1001111);
        check_val("wrap_load_dp", obs_dp, 1'b1);

        // randomized traffic against the model
        for (int f = 0; f < 30; f++) begin
            if (f == 17) do_reset();
            for (int i = 0; i < FRAME; i++) begin
                if ($urandom_range(0, 199) == 0) brightness = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 299) == 0) lz_blank = ~lz_blank;
                if ($urandom_range(0, 39) == 0) begin
                    logic [15:0] mask;
                    mask = 16'h0;
                    for (int k = 0; k < DIGITS; k++)
                        if ($urandom_range(0, 1) == 1) mask[4*k +: 4] = 4'hF;
                    do_load(16'($urandom) & mask, 4'($urandom), 4'($urandom));
                end else begin
                    step();
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
